mc_mem_responder: RTL and testbench

Unified instruction/data memory responder for the multicycle MIPS core. It serves the memory side of the controller's fetch, load and store cycles: it accepts one word request at a time, inserts a fixed number of wait states, then returns read data or commits write data with a single-cycle acknowledge. It sits between the datapath's address mux (PC/ALUOut) and the word-addressed storage array.

---
 rtl/mc_mem_responder_if.sv | 37 +++
 rtl/mc_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_mc_mem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// mc_mem_responder_if
// Request/response bus between the multicycle core's memory-side initiator and
// the unified instruction/data memory responder.
//
// Signals:
//   req    initiator -> responder  request level, held until ack
//   we     initiator -> responder  1 = write, 0 = read
//   addr   initiator -> responder  byte address
//   wdata  initiator -> responder  write data
//   rdata  responder -> initiator  read data, valid in the ack cycle
//   ack    responder -> initiator  one-cycle completion pulse
//   busy   responder -> initiator  high from acceptance through ack
//   err    responder -> initiator  misalignment flag, valid with ack
//
// Modports: master (initiator side), slave (responder side).
// -----------------------------------------------------------------------------
interface mc_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/mc_mem_responder.sv
// -----------------------------------------------------------------------------
// mc_mem_responder
// Unified instruction/data memory responder for the multicycle MIPS core.
// Accepts one word request at a time, inserts WAIT_CYCLES wait states, then
// returns read data or commits write data with a single-cycle ack.
//
// Parameters:
//   DEPTH_LOG2   log2 of storage depth in 32-bit words
//   WAIT_CYCLES  wait states before ack (0..15)
//
// Ports:
//   clk  rising-edge clock
//   clr  synchronous active-high reset (storage contents are kept)
//   bus  mc_mem_responder_if.slave: req/we/addr/wdata in, rdata/ack/busy/err out
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : addr[1:0] != 0 completes with err=1, writes are suppressed
//               and reads return 0.
//   undefined : addr[1:0] is ignored and err is always 0.
// -----------------------------------------------------------------------------
module mc_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  mc_mem_responder_if.slave    bus
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  // Counter preload; the WAIT state exits when the counter reaches zero.
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

`ifdef MISALIGN_TRAP_EN
  // Non-word-aligned byte address.
  function automatic logic misaligned(input logic [1:0] lo);
    return (lo != 2'b00);
  endfunction
`endif

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    mis_q, mis_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic [31:0]             mem_q [0:DEPTH-1];

  // Access performed on the edge that enters RESP.
  logic                    fire_s;
  logic                    acc_we_s;
  logic [DEPTH_LOG2-1:0]   acc_idx_s;
  logic [31:0]             acc_wdata_s;
  logic                    acc_mis_s;
  logic                    mem_we_s;
  logic                    in_mis_s;
  logic                    unused_addr_s;

`ifdef MISALIGN_TRAP_EN
  assign in_mis_s = misaligned(bus.addr[1:0]);
`else
  assign in_mis_s = 1'b0;
`endif

  // Upper address bits wrap away; low bits only matter with the trap enabled.
  assign unused_addr_s = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

  // Next-state, request latching and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    mis_d       = mis_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;
    fire_s      = 1'b0;
    acc_we_s    = we_q;
    acc_idx_s   = idx_q;
    acc_wdata_s = wdata_q;
    acc_mis_s   = mis_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          idx_d   = bus.addr[DEPTH_LOG2+1:2];
          wdata_d = bus.wdata;
          mis_d   = in_mis_s;
          busy_d  = 1'b1;
          if (ZERO_WAIT) begin
            // No wait states: the access happens on the acceptance edge, so
            // it must use the live inputs rather than the latched copies.
            state_d     = S_RESP;
            fire_s      = 1'b1;
            acc_we_s    = bus.we;
            acc_idx_s   = bus.addr[DEPTH_LOG2+1:2];
            acc_wdata_s = bus.wdata;
            acc_mis_s   = in_mis_s;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          fire_s  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (fire_s) begin
      ack_d = 1'b1;
      err_d = acc_mis_s;
      if (acc_we_s) begin
        rdata_d = rdata_q;
      end else if (acc_mis_s) begin
        rdata_d = 32'd0;
      end else begin
        rdata_d = mem_q[acc_idx_s];
      end
    end else begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end
  end

  // clr on the same edge discards an uncommitted write.
  assign mem_we_s = fire_s & acc_we_s & ~acc_mis_s & ~clr;

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage array; deliberately not cleared by clr.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[acc_idx_s] <= acc_wdata_s;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mc_mem_responder
// Self-checking bench: one responder with WAIT_CYCLES=2 (main tests) and one
// with WAIT_CYCLES=0 (back-to-back). Expected data comes from a word-array
// reference model of the storage and the documented latency.
// -----------------------------------------------------------------------------
module tb_mc_mem_responder;

  localparam int W2 = 2;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mc_mem_responder_if bus2();
  mc_mem_responder_if bus0();

  mc_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W2)) u_dut2 (
    .clk (clk),
    .clr (clr),
    .bus (bus2)
  );

  mc_mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .clr (clr),
    .bus (bus0)
  );

  int errors = 0;
  int checks = 0;

  // Reference models: storage contents, which words are defined, held rdata.
  logic [31:0] model2 [256];
  bit          known2 [256];
  logic [31:0] rexp2;
  logic [31:0] model0 [256];
  bit          known0 [256];
  logic [31:0] rexp0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on the WAIT_CYCLES=2 responder, with model update and checks.
  task automatic xact2(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
    int          n;
    logic [7:0]  idx;
    bit          mis;
    logic [31:0] exp_r;
    idx = 8'((a >> 2) % 256);
    mis = TRAP && (a % 4 != 0);
    if (w) begin
      if (!mis) begin
        model2[idx] = d;
        known2[idx] = 1'b1;
      end
      exp_r = rexp2;
    end else begin
      exp_r = mis ? 32'd0 : model2[idx];
    end
    rexp2 = exp_r;

    bus2.req = 1'b1; bus2.we = w; bus2.addr = a; bus2.wdata = d;
    step();
    n = 1;
    while (bus2.ack !== 1'b1 && n < 20) begin
      checks++;
      if (bus2.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_wait: got %b, expected 1 (cycle %0d)", tag, bus2.busy, n);
      end
      checks++;
      if (bus2.err !== 1'b0) begin
        errors++;
        $display("FAIL %s err_wait: got %b, expected 0", tag, bus2.err);
      end
      // Inputs must be ignored while busy.
      bus2.we    = 1'($urandom);
      bus2.addr  = $urandom;
      bus2.wdata = $urandom;
      step();
      n++;
    end
    checks++;
    if (n != W2 + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, n, W2 + 1);
    end
    checks++;
    if (bus2.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_ack: got %b, expected 1", tag, bus2.busy);
    end
    checks++;
    if (bus2.rdata !== exp_r) begin
      errors++;
      $display("FAIL %s rdata: got %h, expected %h", tag, bus2.rdata, exp_r);
    end
    checks++;
    if (bus2.err !== mis) begin
      errors++;
      $display("FAIL %s err: got %b, expected %b", tag, bus2.err, mis);
    end
    bus2.req = 1'b0;
    step();
    checks++;
    if (bus2.ack !== 1'b0 || bus2.busy !== 1'b0 || bus2.err !== 1'b0) begin
      errors++;
      $display("FAIL %s after_ack: ack=%b busy=%b err=%b, expected 0 0 0",
               tag, bus2.ack, bus2.busy, bus2.err);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = 32'd0; bus2.wdata = 32'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0;
    rexp2 = 32'd0;
    rexp0 = 32'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus2.rdata !== 32'd0 || bus2.ack !== 1'b0 || bus2.busy !== 1'b0 || bus2.err !== 1'b0) begin
        errors++;
        $display("FAIL reset: rdata=%h ack=%b busy=%b err=%b, expected 0", bus2.rdata,
                 bus2.ack, bus2.busy, bus2.err);
      end
      checks++;
      if (bus0.rdata !== 32'd0 || bus0.ack !== 1'b0 || bus0.busy !== 1'b0 || bus0.err !== 1'b0) begin
        errors++;
        $display("FAIL reset0: rdata=%h ack=%b busy=%b err=%b, expected 0", bus0.rdata,
                 bus0.ack, bus0.busy, bus0.err);
      end
    end
    clr = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    xact2(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr10");
    xact2(1'b0, 32'h0000_0010, 32'd0, "rd10");
    checks++;
    if (rexp2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd10_model: got %h, expected deadbeef", rexp2);
    end
  endtask

  task automatic test_wrap();
    xact2(1'b1, 32'h0000_0400, 32'h1234_5678, "wr400");
    xact2(1'b0, 32'h0000_0000, 32'd0, "rd000");
    xact2(1'b0, 32'hFFFF_FC00, 32'd0, "rdwrap_hi");
  endtask

  // Continuous req on the zero-wait responder; requests change in ack cycles.
  task automatic test_back_to_back();
    logic        w   [6];
    logic [31:0] a   [6];
    logic [31:0] d   [6];
    logic [31:0] exp_r;
    logic [7:0]  idx;
    bit          mis;
    logic [7:0]  i0;
    logic [7:0]  i1;
    i0 = 8'($urandom_range(0, 127));
    i1 = 8'($urandom_range(128, 255));
    w[0] = 1'b1; a[0] = {22'($urandom), i0, 2'b00}; d[0] = $urandom;
    w[1] = 1'b1; a[1] = {22'($urandom), i1, 2'b00}; d[1] = $urandom;
    w[2] = 1'b0; a[2] = {22'($urandom), i0, 2'b00}; d[2] = $urandom;
    w[3] = 1'b0; a[3] = {22'($urandom), i1, 2'b00}; d[3] = $urandom;
    w[4] = 1'b1; a[4] = {22'($urandom), i0, 2'b01}; d[4] = $urandom;
    w[5] = 1'b0; a[5] = {22'($urandom), i0, 2'b00}; d[5] = $urandom;
    bus0.req = 1'b1; bus0.we = w[0]; bus0.addr = a[0]; bus0.wdata = d[0];
    for (int k = 0; k < 6; k++) begin
      idx = 8'((a[k] >> 2) % 256);
      mis = TRAP && (a[k] % 4 != 0);
      if (w[k]) begin
        if (!mis) begin
          model0[idx] = d[k];
          known0[idx] = 1'b1;
        end
        exp_r = rexp0;
      end else begin
        exp_r = mis ? 32'd0 : model0[idx];
      end
      rexp0 = exp_r;
      step();
      checks++;
      if (bus0.ack !== 1'b1 || bus0.busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ack[%0d]: ack=%b busy=%b, expected 1 1", k, bus0.ack, bus0.busy);
      end
      checks++;
      if (bus0.rdata !== exp_r || bus0.err !== mis) begin
        errors++;
        $display("FAIL b2b_data[%0d]: rdata=%h err=%b, expected %h %b", k, bus0.rdata,
                 bus0.err, exp_r, mis);
      end
      if (k < 5) begin
        bus0.we = w[k+1]; bus0.addr = a[k+1]; bus0.wdata = d[k+1];
      end else begin
        bus0.req = 1'b0;
      end
      step();
      checks++;
      if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: ack=%b busy=%b, expected 0 0", k, bus0.ack, bus0.busy);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen_ack;
    xact2(1'b1, 32'h0000_0020, 32'h0BAD_F00D, "pre20");
    // clr during WAIT: the write is discarded.
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h0000_0020; bus2.wdata = 32'hAAAA_5555;
    step();
    checks++;
    if (bus2.busy !== 1'b1) begin
      errors++;
      $display("FAIL midwr_accept: busy=%b, expected 1", bus2.busy);
    end
    clr = 1'b1;
    bus2.req = 1'b0;
    step();
    clr = 1'b0;
    rexp2 = 32'd0;
    rexp0 = 32'd0;
    seen_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus2.ack !== 1'b0 || bus2.busy !== 1'b0) seen_ack = 1'b1;
      step();
    end
    checks++;
    if (seen_ack) begin
      errors++;
      $display("FAIL midwr_quiet: got ack/busy after clr, expected none");
    end
    xact2(1'b0, 32'h0000_0020, 32'd0, "midwr_read");
    // clr during the ack cycle: the write is already committed.
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h0000_0020; bus2.wdata = 32'h5A5A_C3C3;
    step();
    step();
    step();
    checks++;
    if (bus2.ack !== 1'b1) begin
      errors++;
      $display("FAIL resp_clr_ack: ack=%b, expected 1", bus2.ack);
    end
    clr = 1'b1;
    bus2.req = 1'b0;
    step();
    clr = 1'b0;
    model2[8'h08] = 32'h5A5A_C3C3;
    rexp2 = 32'd0;
    rexp0 = 32'd0;
    checks++;
    if (bus2.ack !== 1'b0 || bus2.busy !== 1'b0 || bus2.rdata !== 32'd0) begin
      errors++;
      $display("FAIL resp_clr_state: ack=%b busy=%b rdata=%h, expected 0 0 0",
               bus2.ack, bus2.busy, bus2.rdata);
    end
    xact2(1'b0, 32'h0000_0020, 32'd0, "resp_clr_read");
  endtask

  task automatic test_clr_with_req();
    xact2(1'b1, 32'h0000_0024, 32'hCAFE_0024, "pre24");
    clr = 1'b1;
    bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h0000_0024; bus2.wdata = 32'h1111_1111;
    step();
    rexp2 = 32'd0;
    rexp0 = 32'd0;
    checks++;
    if (bus2.busy !== 1'b0 || bus2.ack !== 1'b0) begin
      errors++;
      $display("FAIL clr_req: busy=%b ack=%b, expected 0 0", bus2.busy, bus2.ack);
    end
    clr = 1'b0;
    bus2.req = 1'b0;
    step();
    step();
    xact2(1'b0, 32'h0000_0024, 32'd0, "clr_req_read");
  endtask

  task automatic test_misalign();
    xact2(1'b1, 32'h0000_0020, 32'h1111_2222, "mis_pre");
    xact2(1'b1, 32'h0000_0022, 32'h3333_4444, "mis_wr");
    xact2(1'b0, 32'h0000_0020, 32'd0, "mis_chk");
    xact2(1'b0, 32'h0000_0023, 32'd0, "mis_rd");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        w;
    logic [7:0]  idx;
    for (int i = 0; i < 40; i++) begin
      idx = 8'(16 + $urandom_range(0, 15));
      a = {22'($urandom), idx, 2'b00};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      w = 1'($urandom);
      if (!w && !known2[idx] && !(TRAP && a[1:0] != 2'b00)) w = 1'b1;
      xact2(w, a, $urandom, "rand");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      known2[i] = 1'b0;
      known0[i] = 1'b0;
      model2[i] = 32'd0;
      model0[i] = 32'd0;
    end
    test_reset();
    test_write_read();
    test_wrap();
    test_back_to_back();
    test_reset_mid_op();
    test_clr_with_req();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
